// File: rtl/poly_ctrl_pkg.sv
// Shared encodings for the polynomial control block: FSM states, datapath mux
// selects, ULA op codes and the per-state control-word decode.
package poly_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADX = 3'd1,
        SQ    = 3'd2,
        AX2   = 3'd3,
        BX    = 3'd4,
        SUM   = 3'd5,
        ADDC  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [1:0] SEL0_ZERO = 2'b00;
    localparam logic [1:0] SEL0_A    = 2'b01;
    localparam logic [1:0] SEL0_B    = 2'b10;
    localparam logic [1:0] SEL0_C    = 2'b11;

    localparam logic [1:0] SEL1_M0   = 2'b00;
    localparam logic [1:0] SEL1_X    = 2'b01;
    localparam logic [1:0] SEL1_R2   = 2'b10;
    localparam logic [1:0] SEL1_R1   = 2'b11;

    localparam logic [1:0] SEL2_X    = 2'b00;
    localparam logic [1:0] SEL2_M0   = 2'b01;
    localparam logic [1:0] SEL2_R2   = 2'b10;
    localparam logic [1:0] SEL2_R1   = 2'b11;

    localparam logic ULA_ADD = 1'b0;
    localparam logic ULA_MUL = 1'b1;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       lx;
        logic       lh;
        logic       ls;
        logic       busy;
        logic       done;
    } ctrl_t;

    function automatic logic is_op_state(input state_t st);
        return (st == SQ) || (st == AX2) || (st == BX) || (st == SUM) || (st == ADDC);
    endfunction

    function automatic logic is_busy_state(input state_t st);
        return is_op_state(st) || (st == LOADX);
    endfunction

    // Control word for a state; 'load' marks the final cycle of a micro-op.
    function automatic ctrl_t ctrl_decode(input state_t st, input logic load);
        ctrl_t c;
        c = '0;
        case (st)
            IDLE: c = '0;
            LOADX: begin
                c.lx   = 1'b1;
                c.busy = 1'b1;
            end
            SQ: begin
                c.m0 = SEL0_ZERO; c.m1 = SEL1_X;  c.m2 = SEL2_X;  c.h = ULA_MUL;
                c.lh = load;      c.busy = 1'b1;
            end
            AX2: begin
                c.m0 = SEL0_A;    c.m1 = SEL1_M0; c.m2 = SEL2_R1; c.h = ULA_MUL;
                c.lh = load;      c.busy = 1'b1;
            end
            BX: begin
                c.m0 = SEL0_B;    c.m1 = SEL1_M0; c.m2 = SEL2_X;  c.h = ULA_MUL;
                c.ls = load;      c.busy = 1'b1;
            end
            SUM: begin
                c.m0 = SEL0_ZERO; c.m1 = SEL1_R2; c.m2 = SEL2_R1; c.h = ULA_ADD;
                c.lh = load;      c.busy = 1'b1;
            end
            ADDC: begin
                c.m0 = SEL0_C;    c.m1 = SEL1_M0; c.m2 = SEL2_R1; c.h = ULA_ADD;
                c.ls = load;      c.busy = 1'b1;
            end
            DONE: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/poly_step_timer.sv
// Micro-op hold counter: counts up while enabled, clears on request, and flags
// the terminal count (counter == HOLD).
module poly_step_timer #(
    parameter int unsigned HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [3:0] o_cnt,
    output logic       o_tc
);

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    logic [3:0] r_cnt;

    // Hold counter register; clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == HOLD_C);

endmodule

// File: rtl/poly_control_fsm.sv
// Control FSM sequencing P = A*x^2 + B*x + C on the polynomial datapath.
// Optional abort handshake is built when POLY_CTRL_ABORT_EN is defined.
module poly_control_fsm
    import poly_ctrl_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef POLY_CTRL_ABORT_EN
    input  logic       abort,
    output logic       abort_ack,
`endif
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic       busy,
    output logic       done
);

    if ((HOLD < 32'd1) || (HOLD > 32'd15)) begin : g_bad_hold
        $error("poly_control_fsm: HOLD must be within 1..15");
    end

    localparam logic [4:0] HOLD5 = 5'(HOLD);

    state_t     r_state;
    state_t     w_state_nxt;
    ctrl_t      r_ctrl;
    logic       w_load_nxt;
    logic [3:0] w_cnt;
    logic       w_tc;
    logic       w_clr;
    logic       w_load_due;
`ifdef POLY_CTRL_ABORT_EN
    logic       r_ack;
    logic       w_ack_nxt;
`endif

    poly_step_timer #(.HOLD(HOLD)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (1'b1),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // The load is registered one cycle early: it goes high when the counter reaches HOLD.
    assign w_load_due = (({1'b0, w_cnt} + 5'd1) == HOLD5);
    assign w_clr      = !(is_op_state(r_state) && (w_state_nxt == r_state));

    // Next-state and next-load selection.
    always_comb begin
        w_state_nxt = r_state;
        w_load_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = LOADX;
                else       w_state_nxt = IDLE;
            end
            LOADX: w_state_nxt = SQ;
            SQ: begin
                if (w_tc) w_state_nxt = AX2;
                else      w_load_nxt  = w_load_due;
            end
            AX2: begin
                if (w_tc) w_state_nxt = BX;
                else      w_load_nxt  = w_load_due;
            end
            BX: begin
                if (w_tc) w_state_nxt = SUM;
                else      w_load_nxt  = w_load_due;
            end
            SUM: begin
                if (w_tc) w_state_nxt = ADDC;
                else      w_load_nxt  = w_load_due;
            end
            ADDC: begin
                if (w_tc) w_state_nxt = DONE;
                else      w_load_nxt  = w_load_due;
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
`ifdef POLY_CTRL_ABORT_EN
        w_ack_nxt = 1'b0;
        if (abort && is_busy_state(r_state)) begin
            w_state_nxt = IDLE;
            w_load_nxt  = 1'b0;
            w_ack_nxt   = 1'b1;
        end else begin
            w_ack_nxt   = 1'b0;
        end
`endif
    end

    // State and registered control word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
`ifdef POLY_CTRL_ABORT_EN
            r_ack   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= ctrl_decode(w_state_nxt, w_load_nxt);
`ifdef POLY_CTRL_ABORT_EN
            r_ack   <= w_ack_nxt;
`endif
        end
    end

    assign M0   = r_ctrl.m0;
    assign M1   = r_ctrl.m1;
    assign M2   = r_ctrl.m2;
    assign H    = r_ctrl.h;
    assign LX   = r_ctrl.lx;
    assign LH   = r_ctrl.lh;
    assign LS   = r_ctrl.ls;
    assign busy = r_ctrl.busy;
    assign done = r_ctrl.done;
`ifdef POLY_CTRL_ABORT_EN
    assign abort_ack = r_ack;
`endif

endmodule
